program_writer: RTL and testbench
=================================

// Module: program_writer
// PURPOSE
//   Inverse of the instruction decoder: accepts field-level RV32I instruction
//   requests, encodes each into a 32-bit machine word and writes it to memory.
//   Words go to consecutive addresses from a programmable base, over the
//   codebase's valid/ready memory bus. Used for boot-time program injection and
//   as a self-check stimulus source.
// PARAMETERS
//   MAX_WORDS  256  max words written per session; must be a power of 2, >= 2
// PORTS
//   clk           in   1   system clock, rising edge
//   reset         in   1   synchronous, active-low (0 = reset)
//   start         in   1   1-cycle pulse: load base_address, clear count, arm
//   base_address  in   32  first write address; bits [1:0] ignored (forced 0)
//   in_valid      in   1   request valid
//   in_ready      out  1   request accepted when in_valid && in_ready
//   in_fmt        in   3   instr_format_t: R, I, I_SHIFT, S, B, U, J
//   in_opcode     in   7   base_opcode_t
//   in_funct3     in   3   funct3_t
//   in_funct7     in   7   funct7_t (used by R and I_SHIFT only)
//   in_rd/in_rs1/in_rs2  in  5 each  register_index_t
//   in_imm        in   32  signed_word_t, byte offset / full value (U: pre-shifted)
//   mem_valid     out  1   write request valid
//   mem_ready     in   1   write complete when mem_valid && mem_ready
//   mem_address   out  32  word-aligned write address
//   mem_wdata     out  32  encoded instruction
//   mem_wstrobe   out  4   always 4'b1111 while mem_valid, else 0
//   busy          out  1   armed and not full, or a write pending
//   count         out  $clog2(MAX_WORDS)+1  words written this session
//   error         out  1   sticky immediate-range error (see CONFIGURATION)
// BEHAVIOUR
//   Reset: in_ready=0, mem_valid=0, mem_address=0, mem_wdata=0, count=0,
//     busy=0, error=0, state IDLE. Reset mid-write drops the pending word;
//     no partial write is retried.
//   States: IDLE -> (start) ARMED -> (count==MAX_WORDS && no pending) FULL.
//     start in any state returns to ARMED, clears count/error, drops pending.
//   One-entry output register: in_ready = (state==ARMED) && (count+pending <
//     MAX_WORDS) && (!mem_valid || mem_ready). Accept at cycle N -> mem_valid=1
//     with encoded word at N+1. Back-to-back: at 1 accept/cycle while
//     mem_ready=1. mem_address/mem_wdata held stable while mem_valid && !mem_ready.
//   On a mem handshake: mem_address += 4 (wraps mod 2^32), count += 1.
//   Encoding (bit-exact):
//     R:       funct7|rs2|rs1|f3|rd|op
//     I:       imm[11:0]|rs1|f3|rd|op
//     I_SHIFT: funct7|imm[4:0]|rs1|f3|rd|op
//     S:       imm[11:5]|rs2|rs1|f3|imm[4:0]|op
//     B:       imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
//     U:       imm[31:12]|rd|op
//     J:       imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
//     Unused fields ignored. Illegal in_fmt encodes as R.
//   Simultaneous start and in_valid: start wins, request not accepted.
// CONFIGURATION
//   PROGRAM_WRITER_RANGE_CHECK_EN defined: a request whose imm does not fit its
//     format fails the check. Fit means: I/S signed 12b; B signed 13b and even;
//     J signed 21b and even; U with imm[11:0]==0; I_SHIFT with imm in 0..31.
//     A failing request is still consumed (in_ready honoured) but not written.
//     error sets sticky; count is unchanged.
//   Undefined: immediates are truncated silently; error is tied 0.
// STRUCTURE
//   instr_format_t enum goes in opcodes_pkg next to base_opcode_t.
//   Submodule instr_encoder (combinational: fields -> word, plus range_ok)
//   holds all bit packing; program_writer holds the FSM, output register and
//   address/count.
// TESTING
//   start base 0x100; addi x1,x0,5 (I) -> write 0x00500093 @0x100, count=1
//   lui x2,imm 0x12345000 (U) -> write 0x12345137 @0x104
//   beq x1,x2,-4 (B) -> 0xFE208EE3; jal x1,8 (J) -> 0x008000EF, back-to-back
//     with mem_ready=1: one write per cycle
//   mem_ready=0 for 3 cycles -> mem_valid/addr/wdata stable, in_ready=0, no
//     double write; MAX_WORDS=4 -> 5th request stalls, busy=0 after 4th write
//   reset low mid-pending-write -> mem_valid=0 next cycle, count=0
//   RANGE_CHECK_EN: addi imm=2048 -> consumed, no write, error=1, count unchanged

Source files
------------

// File: rtl/opcodes_pkg.sv
// Shared RV32I opcode, format and request types for the program writer slice.
// Macro PROGRAM_WRITER_RANGE_CHECK_EN enables the immediate range helper's use.
package opcodes_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned FUNCT7_W = 7;
  localparam int unsigned FMT_W    = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LOAD   = 7'h03,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_REG    = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F
  } base_opcode_t;

  typedef enum logic [FMT_W-1:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_I_SHIFT = 3'd2,
    FMT_S       = 3'd3,
    FMT_B       = 3'd4,
    FMT_U       = 3'd5,
    FMT_J       = 3'd6
  } instr_format_t;

  // Field-level instruction request as seen by the encoder.
  typedef struct packed {
    logic [FMT_W-1:0]    fmt;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [XLEN-1:0]     imm;
  } instr_req_t;

  // True when v is representable as a two's-complement value of the given width.
  function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned bits);
    logic [XLEN-1:0] hi;
    hi = XLEN'($signed(v) >>> (bits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational RV32I field packer: request fields -> 32-bit machine word.
// PROGRAM_WRITER_RANGE_CHECK_EN enables range_ok; otherwise range_ok is constant 1.
module instr_encoder
  import opcodes_pkg::*;
(
  input  instr_req_t       req,
  output logic [XLEN-1:0]  word,
  output logic             range_ok
);

  // Bit packing per format; unknown formats pack as R.
  always_comb begin
    word = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
    case (req.fmt)
      FMT_I:       word = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      FMT_I_SHIFT: word = {req.funct7, req.imm[4:0], req.rs1, req.funct3, req.rd, req.opcode};
      FMT_S:       word = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0],
                           req.opcode};
      FMT_B:       word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                           req.imm[4:1], req.imm[11], req.opcode};
      FMT_U:       word = {req.imm[31:12], req.rd, req.opcode};
      FMT_J:       word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                           req.rd, req.opcode};
      default:     word = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
    endcase
  end

`ifdef PROGRAM_WRITER_RANGE_CHECK_EN
  // Immediate must be representable in the bits the format actually encodes.
  always_comb begin
    range_ok = 1'b1;
    case (req.fmt)
      FMT_I, FMT_S: range_ok = fits_signed(req.imm, 12);
      FMT_B:        range_ok = fits_signed(req.imm, 13) && !req.imm[0];
      FMT_J:        range_ok = fits_signed(req.imm, 21) && !req.imm[0];
      FMT_U:        range_ok = (req.imm[11:0] == 12'd0);
      FMT_I_SHIFT:  range_ok = (req.imm[31:5] == 27'd0);
      default:      range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

endmodule

// File: rtl/program_writer.sv
// Encodes field-level RV32I requests and writes them to consecutive word addresses.
// PROGRAM_WRITER_RANGE_CHECK_EN (in instr_encoder) drops out-of-range requests and sets error.
module program_writer
  import opcodes_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [31:0]                      base_address,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [2:0]                       in_fmt,
  input  logic [6:0]                       in_opcode,
  input  logic [2:0]                       in_funct3,
  input  logic [6:0]                       in_funct7,
  input  logic [4:0]                       in_rd,
  input  logic [4:0]                       in_rs1,
  input  logic [4:0]                       in_rs2,
  input  logic [31:0]                      in_imm,
  output logic                             mem_valid,
  input  logic                             mem_ready,
  output logic [31:0]                      mem_address,
  output logic [31:0]                      mem_wdata,
  output logic [3:0]                       mem_wstrobe,
  output logic                             busy,
  output logic [$clog2(MAX_WORDS):0]       count,
  output logic                             error
);

  localparam int unsigned CW = $clog2(MAX_WORDS) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            mv_q, mv_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CW-1:0]   count_q, count_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  instr_req_t      req;
  logic [31:0]     enc_word;
  logic            range_ok;
  logic            accept;
  logic            handshake;

  assign req.fmt    = in_fmt;
  assign req.opcode = in_opcode;
  assign req.funct3 = in_funct3;
  assign req.funct7 = in_funct7;
  assign req.rd     = in_rd;
  assign req.rs1    = in_rs1;
  assign req.rs2    = in_rs2;
  assign req.imm    = in_imm;

  instr_encoder u_enc (
    .req      (req),
    .word     (enc_word),
    .range_ok (range_ok)
  );

  // Room exists only if the session cap allows one more word and the output slot frees up.
  always_comb begin
    in_ready = reset && !start && (state_q == S_ARMED)
               && ((32'(count_q) + 32'(mv_q)) < MAX_WORDS)
               && (!mv_q || mem_ready);
  end

  assign accept    = in_valid && in_ready;
  assign handshake = mv_q && mem_ready;

  always_comb begin
    state_d = state_q;
    mv_d    = mv_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    if (start) begin
      state_d = S_ARMED;
      mv_d    = 1'b0;
      addr_d  = base_address & 32'hFFFF_FFFC;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (handshake) begin
        mv_d    = 1'b0;
        addr_d  = addr_q + 32'd4;
        count_d = count_q + CW'(1);
      end
      if (accept) begin
        if (range_ok) begin
          mv_d    = 1'b1;
          wdata_d = enc_word;
        end else begin
          err_d   = 1'b1;
        end
      end
      if ((state_q == S_ARMED) && (count_d == CW'(MAX_WORDS)) && !mv_d) begin
        state_d = S_FULL;
      end
    end
    busy_d = (state_d == S_ARMED) || mv_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mv_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mv_q    <= mv_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign mem_valid   = mv_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrobe = {4{mv_q}};
  assign busy        = busy_q;
  assign count       = count_q;
  assign error       = err_q;

endmodule

// File: tb/tb_program_writer.sv
// Self-checking bench for program_writer: directed spec cases plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_program_writer;

  localparam int MAX = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_address;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrobe;
  logic        busy;
  logic [2:0]  count;
  logic        error;

  program_writer #(.MAX_WORDS(MAX)) dut (
    .clk(clk), .reset(reset), .start(start), .base_address(base_address),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_wstrobe(mem_wstrobe),
    .busy(busy), .count(count), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: session armed, words written, sticky error, one-deep pending slot.
  bit          m_armed = 0;
  int          m_cnt   = 0;
  bit          m_err   = 0;
  bit          m_pend  = 0;
  logic [31:0] m_addr  = 32'd0;
  logic [31:0] m_word  = 32'd0;
  bit          m_acc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_enc(input logic [2:0] fmt, input logic [31:0] op,
      input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] rd,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    case (fmt)
      3'd1: w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
      3'd2: w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'h1F) << 20)
                | (f7 << 25);
      3'd3: w = op | ((imm & 32'h1F) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                | (((imm >> 5) & 32'h7F) << 25);
      3'd4: w = op | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
      3'd5: w = op | (rd << 7) | (imm & 32'hFFFF_F000);
      3'd6: w = op | (rd << 7) | (((imm >> 12) & 32'hFF) << 12)
                | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 20) & 32'h1) << 31);
      default: w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
    endcase
    return w;
  endfunction

  function automatic bit ref_fits(input logic [2:0] fmt, input logic [31:0] imm);
`ifdef PROGRAM_WRITER_RANGE_CHECK_EN
    int s;
    s = $signed(imm);
    case (fmt)
      3'd1, 3'd3: return (s >= -2048) && (s <= 2047);
      3'd4:       return (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
      3'd6:       return (s >= -1048576) && (s <= 1048575) && (imm[0] == 1'b0);
      3'd5:       return (imm % 4096) == 0;
      3'd2:       return imm <= 32'd31;
      default:    return 1'b1;
    endcase
`else
    return (fmt == fmt) || (imm == imm);
`endif
  endfunction

  function automatic bit exp_ready();
    return reset && !start && m_armed && ((m_cnt + int'(m_pend)) < MAX)
           && (!m_pend || mem_ready);
  endfunction

  // Per-cycle compare of every output against the model, then model advance.
  task automatic step();
    bit acc;
    #1;
    chk("in_ready", 32'(in_ready), 32'(exp_ready()));
    chk("mem_valid", 32'(mem_valid), 32'(m_pend));
    chk("mem_wstrobe", 32'(mem_wstrobe), m_pend ? 32'hF : 32'h0);
    chk("count", 32'(count), 32'(m_cnt));
    chk("busy", 32'(busy), 32'((m_armed && !(m_cnt == MAX && !m_pend)) || m_pend));
    chk("error", 32'(error), 32'(m_err));
    if (m_pend) begin
      chk("mem_address", mem_address, m_addr);
      chk("mem_wdata", mem_wdata, m_word);
    end
    acc   = in_valid && exp_ready();
    m_acc = acc;
    if (!reset) begin
      m_armed = 0; m_cnt = 0; m_err = 0; m_pend = 0; m_addr = 32'd0;
    end else if (start) begin
      m_armed = 1; m_cnt = 0; m_err = 0; m_pend = 0; m_addr = base_address & ~32'd3;
    end else begin
      if (m_pend && mem_ready) begin
        m_cnt++;
        m_addr = m_addr + 32'd4;
        m_pend = 0;
      end
      if (acc) begin
        if (ref_fits(in_fmt, in_imm)) begin
          m_pend = 1;
          m_word = ref_enc(in_fmt, 32'(in_opcode), 32'(in_funct3), 32'(in_funct7),
                           32'(in_rd), 32'(in_rs1), 32'(in_rs2), in_imm);
        end else begin
          m_err = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Hold in_valid until the model sees acceptance, bounded.
  task automatic send();
    int n;
    n = 0;
    in_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!m_acc && n < 20);
    chk("send_accepted", 32'(m_acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] base);
    start = 1'b1; base_address = base;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_address = 32'd0; in_valid = 1'b0; mem_ready = 1'b0;
    set_req(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    step();

    // Pin the reference encoder itself.
    chk("ref_addi", ref_enc(3'd1, 32'h13, 0, 0, 1, 0, 0, 32'd5), 32'h0050_0093);
    chk("ref_lui", ref_enc(3'd5, 32'h37, 0, 0, 2, 0, 0, 32'h1234_5000), 32'h1234_5137);
    chk("ref_beq", ref_enc(3'd4, 32'h63, 0, 0, 0, 1, 2, 32'hFFFF_FFFC), 32'hFE20_8EE3);
    chk("ref_jal", ref_enc(3'd6, 32'h6F, 0, 0, 1, 0, 0, 32'd8), 32'h0080_00EF);

    // Directed session: base bits [1:0] are dropped.
    do_start(32'h0000_0103);
    mem_ready = 1'b1;
    set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    send();
    chk("addi_addr", mem_address, 32'h100);
    chk("addi_word", mem_wdata, 32'h0050_0093);
    set_req(3'd5, 7'h37, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h1234_5000);
    send();
    chk("addi_count", 32'(count), 32'd1);
    chk("lui_addr", mem_address, 32'h104);
    chk("lui_word", mem_wdata, 32'h1234_5137);
    set_req(3'd4, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    send();
    chk("lui_count", 32'(count), 32'd2);
    chk("beq_addr", mem_address, 32'h108);
    chk("beq_word", mem_wdata, 32'hFE20_8EE3);

    // Back-pressure: slot must hold and nothing new accepted.
    mem_ready = 1'b0;
    set_req(3'd6, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("stall_valid", 32'(mem_valid), 32'd1);
      chk("stall_addr", mem_address, 32'h108);
      chk("stall_word", mem_wdata, 32'hFE20_8EE3);
      chk("stall_count", 32'(count), 32'd2);
    end
    mem_ready = 1'b1;
    send();
    chk("jal_count", 32'(count), 32'd3);
    chk("jal_addr", mem_address, 32'h10C);
    chk("jal_word", mem_wdata, 32'h0080_00EF);

    // Fifth request must stall; session full after the fourth write.
    set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd1);
    in_valid = 1'b1;
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("full_count", 32'(count), 32'd4);
    chk("full_valid", 32'(mem_valid), 32'd0);
    chk("full_busy", 32'(busy), 32'd0);
    step();
    in_valid = 1'b0;

    // Reset while a write is pending drops it.
    do_start(32'h0000_0200);
    mem_ready = 1'b0;
    set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    send();
    chk("pend_valid", 32'(mem_valid), 32'd1);
    reset = 1'b0;
    step();
    chk("rstmid_valid", 32'(mem_valid), 32'd0);
    chk("rstmid_count", 32'(count), 32'd0);
    reset = 1'b1;
    step();

    // Out-of-range I immediate.
    do_start(32'h0000_0300);
    mem_ready = 1'b1;
    set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    send();
`ifdef PROGRAM_WRITER_RANGE_CHECK_EN
    chk("rng_valid", 32'(mem_valid), 32'd0);
    chk("rng_error", 32'(error), 32'd1);
    step();
    chk("rng_count", 32'(count), 32'd0);
`else
    chk("rng_valid", 32'(mem_valid), 32'd1);
    chk("rng_word", mem_wdata, 32'h8000_0093);
    chk("rng_error", 32'(error), 32'd0);
    step();
    chk("rng_count", 32'(count), 32'd1);
`endif

    // Randomized traffic with occasional restarts and resets.
    for (int c = 0; c < 4000; c++) begin
      reset        = ($urandom_range(0, 399) != 0);
      start        = ($urandom_range(0, 29) == 0);
      base_address = $urandom;
      in_valid     = $urandom_range(0, 1) == 1;
      mem_ready    = $urandom_range(0, 9) < 7;
      in_fmt       = 3'($urandom_range(0, 7));
      in_opcode    = 7'($urandom);
      in_funct3    = 3'($urandom);
      in_funct7    = 7'($urandom);
      in_rd        = 5'($urandom);
      in_rs1       = 5'($urandom);
      in_rs2       = 5'($urandom);
      case ($urandom_range(0, 2))
        0:       in_imm = $urandom;
        1:       in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        default: in_imm = $urandom & 32'hFFFF_F000;
      endcase
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
